// File: rtl/score_ram_pkg.sv
// score_ram_pkg: shared types and constants for the score RAM responder.
package score_ram_pkg;
  typedef enum logic {CLEAR, SERVE} state_e;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/score_ram_array.sv
// score_ram_array: DEPTH x DATA_W register array, one write port, combinational read.
module score_ram_array #(
  parameter int DEPTH = 16,
  parameter int DATA_W = 8,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/score_ram_responder.sv
// score_ram_responder: self-clearing score memory serving one read/write per clock,
// optionally keeping only the highest value written to each entry.
module score_ram_responder import score_ram_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 8,
  parameter int KEEP_MAX = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_in,
  input  logic              r_w,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              addr_err,
  output logic              updated
);
  localparam int IW = $clog2(DEPTH);
  state_e state_q, state_d;
  logic [IW-1:0] sweep_q, sweep_d, idx, waddr;
  logic [DATA_W-1:0] old_val, new_val, wdata, data_q, data_d;
  logic serve, in_range, wr, bigger, store, we, err_q, err_d, upd_q, upd_d;
  assign serve = state_q == SERVE;
  assign in_range = 32'(address_in) < 32'(DEPTH);
  assign idx = address_in[IW-1:0];
  score_ram_array #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_array (
    .clk(clk), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(idx), .rdata_o(old_val)
  );
  // The sweep owns the write port until SERVE; afterwards only accepted writes use it.
  always_comb begin
    bigger = data_in > old_val;
    store = (KEEP_MAX == 0) || bigger;
    wr = serve && in_range && r_w == RW_WRITE;
    new_val = store ? data_in : old_val;
    we = !serve || (wr && store);
    waddr = serve ? idx : sweep_q;
    wdata = serve ? data_in : '0;
    sweep_d = serve ? sweep_q : sweep_q + 1'b1;
    state_d = (!serve && sweep_q == IW'(DEPTH - 1)) ? SERVE : state_q;
    data_d = (!serve || !in_range) ? '0 : (r_w == RW_READ ? old_val : new_val);
    err_d = serve && !in_range;
    upd_d = wr && ((KEEP_MAX != 0) ? bigger : data_in != old_val);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= CLEAR;
      sweep_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      data_q <= data_d;
      err_q <= err_d;
      upd_q <= upd_d;
    end
  assign data_out = data_q;
  assign ready = serve;
  assign addr_err = err_q;
  assign updated = upd_q;
endmodule

// File: tb/tb_score_ram_responder.sv
// tb_score_ram_responder: scoreboard bench for max-keeping and overwrite variants side by side.
module tb_score_ram_responder;
  logic clk = 1'b0, reset = 1'b1, r_w = 1'b0;
  logic [7:0] address_in = '0, data_in = '0;
  logic [7:0] d1, d0;
  logic rdy1, rdy0, e1, e0, u1, u0;
  typedef struct {logic [7:0] d1, d0; logic e, u1, u0;} exp_t;
  exp_t sb[$];
  logic [7:0] m1 [16];
  logic [7:0] m0 [16];
  int checks = 0, passes = 0;

  always #10 clk = ~clk;

  score_ram_responder #(.DEPTH(16), .DATA_W(8), .ADDR_W(8), .KEEP_MAX(1)) dut (
    .clk(clk), .reset(reset), .address_in(address_in), .r_w(r_w), .data_in(data_in),
    .data_out(d1), .ready(rdy1), .addr_err(e1), .updated(u1));
  score_ram_responder #(.DEPTH(16), .DATA_W(8), .ADDR_W(8), .KEEP_MAX(0)) dut0 (
    .clk(clk), .reset(reset), .address_in(address_in), .r_w(r_w), .data_in(data_in),
    .data_out(d0), .ready(rdy0), .addr_err(e0), .updated(u0));

  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
    exp_t x;
    x.e = a >= 8'd16; x.u1 = 1'b0; x.u0 = 1'b0; x.d1 = '0; x.d0 = '0;
    if (!x.e) begin
      if (w) begin
        if (d > m1[a[3:0]]) begin m1[a[3:0]] = d; x.u1 = 1'b1; end
        x.u0 = d != m0[a[3:0]];
        m0[a[3:0]] = d;
      end
      x.d1 = m1[a[3:0]]; x.d0 = m0[a[3:0]];
    end
    sb.push_back(x);
    r_w = w; address_in = a; data_in = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin m1[i] = '0; m0[i] = '0; end
  endtask

  task automatic run_reqs(input string name, input logic [16:0] rq [$]);
    exp_t x;
    foreach (rq[i]) begin
      issue(rq[i][16], rq[i][15:8], rq[i][7:0]);
      @(negedge clk);
      x = sb.pop_front();
      checks++;
      if ({rdy1, d1, e1, u1, rdy0, d0, e0, u0} !== {1'b1, x.d1, x.e, x.u1, 1'b1, x.d0, x.e, x.u0})
        $display("FAIL %s req%0d a=%h: got rdy/d/err/upd %b/%h/%b/%b and %b/%h/%b/%b, want 1/%h/%b/%b and 1/%h/%b/%b",
                 name, i, rq[i][15:8], rdy1, d1, e1, u1, rdy0, d0, e0, u0, x.d1, x.e, x.u1, x.d0, x.e, x.u0);
      else passes++;
    end
    r_w = 1'b0; address_in = '0; data_in = '0;
  endtask

  task automatic read_all(input string name);
    logic [16:0] rq [$];
    for (int i = 0; i < 16; i++) rq.push_back({1'b0, 8'(i), 8'h00});
    run_reqs(name, rq);
  endtask

  task automatic sweep_wait(input string name);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      checks++;
      if ({rdy1, rdy0, d1, d0, e1, e0, u1, u0} !== {{2{j == 16}}, 20'h0})
        $display("FAIL %s cycle%0d: got rdy=%b/%b d=%h/%h err=%b upd=%b, want rdy=%b and zeros",
                 name, j, rdy1, rdy0, d1, d0, e1, u1, j == 16);
      else passes++;
    end
    clear_model();
  endtask

  task automatic test_reset();
    #5 reset = 1'b0;
    #1;
    checks++;
    if ({rdy1, rdy0, d1, d0, e1, e0, u1, u0} !== 22'h0)
      $display("FAIL reset_state: got rdy=%b d=%h err=%b upd=%b, want all 0", rdy1, d1, e1, u1);
    else passes++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sweep_wait("reset_sweep");
    read_all("reset_read");
  endtask

  task automatic test_keep_max();
    run_reqs("keep_max", '{{1'b1, 8'd2, 8'h05}, {1'b1, 8'd2, 8'h03}, {1'b1, 8'd2, 8'h05},
                           {1'b1, 8'd2, 8'h09}, {1'b0, 8'd2, 8'h00}});
  endtask

  task automatic test_out_of_range();
    run_reqs("out_of_range", '{{1'b1, 8'h10, 8'h7F}, {1'b0, 8'hFF, 8'h00}});
    read_all("oor_unchanged");
  endtask

  task automatic test_back_to_back();
    run_reqs("back_to_back", '{{1'b1, 8'd3, 8'h21}, {1'b0, 8'd3, 8'h00}});
  endtask

  task automatic test_keep_max0();
    run_reqs("overwrite", '{{1'b1, 8'd1, 8'h09}, {1'b1, 8'd1, 8'h02}, {1'b0, 8'd1, 8'h00}});
  endtask

  task automatic test_random();
    logic [16:0] rq [$];
    for (int i = 0; i < 40; i++)
      rq.push_back({1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)), 8'($urandom)});
    run_reqs("random", rq);
  endtask

  task automatic test_mid_sweep_reset();
    logic [16:0] rq [$];
    for (int i = 0; i < 16; i++) rq.push_back({1'b1, 8'(i), 8'hAA});
    for (int i = 0; i < 16; i++) rq.push_back({1'b0, 8'(i), 8'h00});
    run_reqs("fill_aa", rq);
    issue(1'b1, 8'd15, 8'hAA);
    @(negedge clk);
    void'(sb.pop_front());
    reset = 1'b0;
    #1;
    checks++;
    if ({rdy1, rdy0, d1, d0} !== 18'h0)
      $display("FAIL async_reset: got rdy=%b d=%h, want rdy=0 d=00", rdy1, d1);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    r_w = 1'b1; address_in = 8'd0; data_in = 8'hFF;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sweep_wait("mid_sweep");
    read_all("mid_sweep_read");
  endtask

  initial begin
    test_reset();
    test_keep_max();
    test_out_of_range();
    test_back_to_back();
    test_keep_max0();
    test_random();
    test_mid_sweep_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
